// File: rtl/bus_arbiter_param.sv
// bus_arbiter_param: N-master one-hot bus arbiter, fixed-priority or round-robin, optional no-ack timeout
module bus_arbiter_param #(
  parameter int N_MASTERS = 4,
  parameter int RR_MODE   = 0,
  parameter int TIMEOUT   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_MASTERS-1:0]         bus_req,
  input  logic                         bus_ack,
  output logic [N_MASTERS-1:0]         bus_grant,
  output logic [$clog2(N_MASTERS)-1:0] grant_idx,
  output logic                         timeout_evt
);
  localparam int IW = $clog2(N_MASTERS);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [IW-1:0] ptr, base, win_idx;
  logic [IW:0] j;
  logic [N_MASTERS-1:0] cand;
  logic win_vld, expire, arb;
  generate
    if (TIMEOUT > 0) begin : g_to
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt;
      assign expire = state == BUSY && !bus_ack && cnt == CW'(TIMEOUT - 1);
      always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else cnt <= (state == BUSY && !bus_ack && !expire) ? cnt + 1'b1 : '0;
    end else begin : g_no_to
      assign expire = 1'b0;
    end
  endgenerate
  assign arb  = state == IDLE || bus_ack || expire;
  assign base = RR_MODE != 0 ? ptr : '0;
  // On timeout the current holder sits out this one arbitration
  always_comb begin
    cand    = bus_req & ~(expire ? bus_grant : '0);
    win_vld = 1'b0;
    win_idx = '0;
    j       = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      j = {1'b0, base} + (IW+1)'(i);
      j = j >= (IW+1)'(N_MASTERS) ? j - (IW+1)'(N_MASTERS) : j;
      if (!win_vld && cand[j[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = j[IW-1:0];
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      bus_grant   <= '0;
      grant_idx   <= '0;
      timeout_evt <= 1'b0;
      ptr         <= '0;
    end else begin
      timeout_evt <= expire;
      if (arb) begin
        state     <= win_vld ? BUSY : IDLE;
        bus_grant <= win_vld ? {{(N_MASTERS-1){1'b0}}, 1'b1} << win_idx : '0;
        grant_idx <= win_vld ? win_idx : '0;
        if (win_vld) ptr <= win_idx == IW'(N_MASTERS - 1) ? '0 : win_idx + 1'b1;
      end
    end
endmodule

// File: tb/tb_bus_arbiter_param.sv
// tb_bus_arbiter_param: fixed, round-robin and timeout arbiters against a behavioural model
module tb_bus_arbiter_param;
  localparam int RRC [3] = '{0, 1, 0};
  localparam int TOC [3] = '{0, 0, 3};
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] bus_req = '0;
  logic bus_ack = 1'b0;
  logic [3:0] g [3];
  logic [1:0] gi [3];
  logic te [3];
  int n_chk = 0, n_fail = 0;
  int holder [3], ptr [3], cnt [3];
  bit evt [3];

  always #5 clk = ~clk;

  bus_arbiter_param #(.N_MASTERS(4), .RR_MODE(0), .TIMEOUT(0)) u_fix (.clk(clk), .reset(reset),
    .bus_req(bus_req), .bus_ack(bus_ack), .bus_grant(g[0]), .grant_idx(gi[0]), .timeout_evt(te[0]));
  bus_arbiter_param #(.N_MASTERS(4), .RR_MODE(1), .TIMEOUT(0)) u_rr (.clk(clk), .reset(reset),
    .bus_req(bus_req), .bus_ack(bus_ack), .bus_grant(g[1]), .grant_idx(gi[1]), .timeout_evt(te[1]));
  bus_arbiter_param #(.N_MASTERS(4), .RR_MODE(0), .TIMEOUT(3)) u_to (.clk(clk), .reset(reset),
    .bus_req(bus_req), .bus_ack(bus_ack), .bus_grant(g[2]), .grant_idx(gi[2]), .timeout_evt(te[2]));

  always @(negedge clk)
    for (int c = 0; c < 3; c++) begin
      n_chk++;
      if ((g[c] & (g[c] - 4'd1)) != 4'd0) begin
        n_fail++;
        $display("FAIL onehot dut%0d t=%0t grant=%b required zero or one-hot", c, $time, g[c]);
      end
    end

  function automatic int pick(int c, logic [3:0] r, int excl);
    for (int k = 0; k < 4; k++) begin
      int m = RRC[c] != 0 ? (ptr[c] + k) % 4 : k;
      if (r[m] && m != excl) return m;
    end
    return -1;
  endfunction

  function automatic void arbitrate(int c, logic [3:0] r, int excl);
    holder[c] = pick(c, r, excl);
    if (holder[c] >= 0) ptr[c] = (holder[c] + 1) % 4;
    cnt[c] = 0;
  endfunction

  function automatic void model_edge(logic [3:0] r, logic a);
    for (int c = 0; c < 3; c++) begin
      evt[c] = 0;
      if (holder[c] < 0 || a) arbitrate(c, r, -1);
      else begin
        cnt[c]++;
        if (TOC[c] > 0 && cnt[c] == TOC[c]) begin
          evt[c] = 1;
          arbitrate(c, r, holder[c]);
        end
      end
    end
  endfunction

  function automatic logic [3:0] exp_g(int c);
    return holder[c] < 0 ? 4'd0 : 4'd1 << holder[c];
  endfunction

  task automatic step(input logic [3:0] r, input logic a);
    bus_req = r;
    bus_ack = a;
    model_edge(r, a);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus_req = '0;
    bus_ack = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      holder[c] = -1; ptr[c] = 0; cnt[c] = 0; evt[c] = 0;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_chk++;
      if (g[c] !== 4'd0 || gi[c] !== 2'd0 || te[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset dut%0d grant=%b idx=%0d evt=%b required 0000 0 0", c, g[c], gi[c], te[c]);
      end
    end
    do_reset();
  endtask

  task automatic test_fixed_hold();
    do_reset();
    step(4'b0110, 1'b0);
    n_chk++;
    if (g[0] !== 4'b0010 || gi[0] !== 2'd1) begin
      n_fail++;
      $display("FAIL fixed_grant grant=%b idx=%0d required 0010 1", g[0], gi[0]);
    end
    for (int i = 0; i < 5; i++) begin
      step(4'b0001, 1'b0);
      n_chk++;
      if (g[0] !== 4'b0010 || gi[0] !== 2'd1) begin
        n_fail++;
        $display("FAIL fixed_hold cyc%0d grant=%b idx=%0d required 0010 1", i, g[0], gi[0]);
      end
    end
  endtask

  task automatic test_ack_idle();
    step(4'b0000, 1'b1);
    n_chk++;
    if (g[0] !== 4'b0000 || gi[0] !== 2'd0) begin
      n_fail++;
      $display("FAIL ack_release grant=%b idx=%0d required 0000 0", g[0], gi[0]);
    end
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b1);
      n_chk++;
      if (g[0] !== 4'b0000 || g[1] !== 4'b0000) begin
        n_fail++;
        $display("FAIL ack_idle cyc%0d grant=%b/%b required 0000", i, g[0], g[1]);
      end
    end
  endtask

  task automatic test_rr_wrap();
    logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1);
      n_chk++;
      if (g[1] !== seq[i]) begin
        n_fail++;
        $display("FAIL rr_wrap step%0d grant=%b required %b", i, g[1], seq[i]);
      end
    end
  endtask

  task automatic test_rr_holder3();
    do_reset();
    step(4'b1000, 1'b0);
    step(4'b1001, 1'b1);
    n_chk++;
    if (g[1] !== 4'b0001 || gi[1] !== 2'd0) begin
      n_fail++;
      $display("FAIL rr_after3 grant=%b idx=%0d required 0001 0", g[1], gi[1]);
    end
    step(4'b1001, 1'b1);
    n_chk++;
    if (g[1] !== 4'b1000 || gi[1] !== 2'd3) begin
      n_fail++;
      $display("FAIL rr_after0 grant=%b idx=%0d required 1000 3", g[1], gi[1]);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step(4'b0001, 1'b0);
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b0);
    n_chk++;
    if (g[2] !== 4'b0001 || te[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL to_pre grant=%b evt=%b required 0001 0", g[2], te[2]);
    end
    step(4'b0011, 1'b0);
    n_chk++;
    if (g[2] !== 4'b0010 || gi[2] !== 2'd1 || te[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL to_fire grant=%b idx=%0d evt=%b required 0010 1 1", g[2], gi[2], te[2]);
    end
    step(4'b0011, 1'b0);
    n_chk++;
    if (g[2] !== 4'b0010 || te[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL to_pulse grant=%b evt=%b required 0010 0", g[2], te[2]);
    end
    do_reset();
    step(4'b0001, 1'b0);
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b1);
    n_chk++;
    if (g[2] !== 4'b0001 || te[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL to_ack grant=%b evt=%b required 0001 0", g[2], te[2]);
    end
    step(4'b0011, 1'b0);
    n_chk++;
    if (te[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL to_ack_nopulse evt=%b required 0", te[2]);
    end
  endtask

  task automatic test_reset_midbusy();
    do_reset();
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b1);
    #4;
    reset = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_chk++;
      if (g[c] !== 4'd0 || gi[c] !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_async dut%0d grant=%b idx=%0d required 0000 0", c, g[c], gi[c]);
      end
    end
    do_reset();
    step(4'b1111, 1'b0);
    for (int c = 0; c < 3; c++) begin
      n_chk++;
      if (g[c] !== 4'b0001) begin
        n_fail++;
        $display("FAIL reset_ptr dut%0d grant=%b required 0001", c, g[c]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
      for (int c = 0; c < 3; c++) begin
        n_chk++;
        if (g[c] !== exp_g(c) || gi[c] !== 2'(holder[c] < 0 ? 0 : holder[c]) || te[c] !== evt[c]) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d grant=%b idx=%0d evt=%b required %b %0d %b",
                   c, i, g[c], gi[c], te[c], exp_g(c), holder[c] < 0 ? 0 : holder[c], evt[c]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fixed_hold();
    test_ack_idle();
    test_rr_wrap();
    test_rr_holder3();
    test_timeout();
    test_reset_midbusy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
